// File: rtl/token_retime_buf_pkg.sv
// Shared types and helpers for the token retiming buffer.
//   fsm_tokbuf  : watermark state machine encoding (EMPTY, FILL, HOLD)
//   count_width : bit width needed to hold an occupancy of 0..depth
package token_retime_buf_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    HOLD  = 2'd2
  } fsm_tokbuf;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/token_fifo_core.sv
// Elastic storage for the token retiming buffer: DEPTH-entry circular queue
// with write/read pointers and an occupancy counter. The caller qualifies
// push and pop; this block never refuses a request on its own.
// Ports:
//   clock, reset : clock and synchronous active-high reset (clears storage too)
//   push, pop    : qualified enqueue / dequeue strobes for this cycle
//   data         : token written on push
//   head         : token at the read pointer (registered storage, no bypass)
//   count        : current occupancy, 0..DEPTH
//   full, empty  : occupancy == DEPTH / occupancy == 0
module token_fifo_core
  import token_retime_buf_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            push,
  input  logic                            pop,
  input  logic [WIDTH-1:0]                data,
  output logic [WIDTH-1:0]                head,
  output logic [count_width(DEPTH)-1:0]   count,
  output logic                            full,
  output logic                            empty
);

  localparam int CW = count_width(DEPTH);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] storage [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        storage[i] <= '0;
      end
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        storage[wptr] <= data;
        wptr          <= wptr + PW'(1);
      end
      if (pop) begin
        rptr <= rptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign head  = storage[rptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/token_retime_buf.sv
// Parametrised Valid/Nack token retiming buffer. Tokens from an upstream
// producer are queued in a DEPTH-entry elastic buffer and presented to the
// downstream consumer. A registered Nack is raised toward upstream once
// occupancy reaches DEPTH-SKID, leaving SKID entries for tokens already in
// flight, and is released only when occupancy falls to LO_MARK or below.
// Ports:
//   clock, reset : clock and synchronous active-high reset
//   I_Valid      : token present from upstream
//   I_Data       : token payload
//   I_Nack       : downstream refuses the head token this cycle
//   O_Valid      : queue non-empty, head token offered downstream
//   O_Data       : head-of-queue token
//   O_Nack       : backpressure to upstream (registered, hysteretic)
//   O_Count      : current occupancy
//   O_Overflow   : sticky, set when a token arrived while full and not popping
module token_retime_buf
  import token_retime_buf_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int SKID    = 2,
  parameter int LO_MARK = 1
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            I_Valid,
  input  logic [WIDTH-1:0]                I_Data,
  input  logic                            I_Nack,
  output logic                            O_Valid,
  output logic [WIDTH-1:0]                O_Data,
  output logic                            O_Nack,
  output logic [count_width(DEPTH)-1:0]   O_Count,
  output logic                            O_Overflow
);

  localparam int            CW      = count_width(DEPTH);
  localparam logic [CW-1:0] HI_MARK = CW'(DEPTH - SKID);
  localparam logic [CW-1:0] LO_LVL  = CW'(LO_MARK);

  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  fsm_tokbuf     state;
  fsm_tokbuf     state_next;

  token_fifo_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_core (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .data  (I_Data),
    .head  (O_Data),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign O_Valid = ~empty;
  assign O_Count = count;

  // A full queue still accepts a token when the head leaves the same cycle.
  assign pop  = O_Valid & ~I_Nack;
  assign push = I_Valid & (~full | pop);

  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // Watermark transitions look at post-edge occupancy so Nack rises on the
  // edge after the push that crosses DEPTH-SKID.
  always_comb begin
    state_next = EMPTY;
    case (state)
      EMPTY: begin
        if (count_next >= HI_MARK)   state_next = HOLD;
        else if (count_next != '0)   state_next = FILL;
        else                         state_next = EMPTY;
      end
      FILL: begin
        if (count_next >= HI_MARK)   state_next = HOLD;
        else if (count_next == '0)   state_next = EMPTY;
        else                         state_next = FILL;
      end
      HOLD: begin
        // Between LO_MARK and HI_MARK the Nack is held: hysteresis band.
        if (count_next == '0)        state_next = EMPTY;
        else if (count_next <= LO_LVL) state_next = FILL;
        else                         state_next = HOLD;
      end
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= EMPTY;
      O_Nack     <= 1'b0;
      O_Overflow <= 1'b0;
    end else begin
      state  <= state_next;
      O_Nack <= (state_next == HOLD);
      if (I_Valid & ~push) begin
        O_Overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_token_retime_buf.sv
module tb_token_retime_buf;

  logic        clock = 1'b0;
  logic        reset;
  logic        I_Valid;
  logic [31:0] I_Data;
  logic        I_Nack;
  logic        O_Valid;
  logic [31:0] O_Data;
  logic        O_Nack;
  logic [2:0]  O_Count;
  logic        O_Overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit        rst;
    bit        v;
    bit [31:0] d;
    bit        n;
    bit        ev;
    bit [31:0] ed;
    bit        en;
    int        ec;
    bit        eo;
  } vec_t;

  vec_t vecs[$];

  token_retime_buf #(
    .WIDTH   (32),
    .DEPTH   (4),
    .SKID    (2),
    .LO_MARK (1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .I_Valid    (I_Valid),
    .I_Data     (I_Data),
    .I_Nack     (I_Nack),
    .O_Valid    (O_Valid),
    .O_Data     (O_Data),
    .O_Nack     (O_Nack),
    .O_Count    (O_Count),
    .O_Overflow (O_Overflow)
  );

  always #5 clock = ~clock;

  function automatic vec_t mk(bit rst, bit v, bit [31:0] d, bit n,
                              bit ev, bit [31:0] ed, bit en, int ec, bit eo);
    vec_t r;
    r.rst = rst; r.v = v; r.d = d; r.n = n;
    r.ev = ev; r.ed = ed; r.en = en; r.ec = ec; r.eo = eo;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit rst, input bit v, input bit [31:0] d, input bit n);
    reset   = rst;
    I_Valid = v;
    I_Data  = d;
    I_Nack  = n;
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input bit ev, input bit [31:0] ed,
                           input bit en, input int ec, input bit eo);
    check({tag, ".valid"}, {31'd0, O_Valid}, {31'd0, ev});
    check({tag, ".count"}, {29'd0, O_Count}, ec);
    check({tag, ".nack"}, {31'd0, O_Nack}, {31'd0, en});
    check({tag, ".ovf"}, {31'd0, O_Overflow}, {31'd0, eo});
    if (ev) check({tag, ".data"}, O_Data, ed);
  endtask

  initial begin
    // Reset state
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    check_all("reset", 0, 0, 0, 0, 0);
    check("reset.data0", O_Data, 32'd0);

    // Pass-through: tokens 1..8 back to back, one-cycle latency, Count stays 1
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(0, 1, k, 0, 1, k, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Watermark: downstream stalled, push 1..4; Nack after Count reaches 2
    vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 2, 1, 1, 1, 1, 2, 0));
    vecs.push_back(mk(0, 1, 3, 1, 1, 1, 1, 3, 0));
    vecs.push_back(mk(0, 1, 4, 1, 1, 1, 1, 4, 0));
    // Overflow: full, stalled, token 9 dropped
    vecs.push_back(mk(0, 1, 9, 1, 1, 1, 1, 4, 1));
    // Release with hysteresis; drain shows 2,3,4 and no 9
    vecs.push_back(mk(0, 0, 0, 0, 1, 2, 1, 3, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 1, 2, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1));
    // Reset clears sticky overflow
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
    // Full simultaneous push/pop
    vecs.push_back(mk(0, 1, 1, 1, 1, 1, 0, 1, 0));
    vecs.push_back(mk(0, 1, 2, 1, 1, 1, 1, 2, 0));
    vecs.push_back(mk(0, 1, 3, 1, 1, 1, 1, 3, 0));
    vecs.push_back(mk(0, 1, 4, 1, 1, 1, 1, 4, 0));
    vecs.push_back(mk(0, 1, 5, 0, 1, 2, 1, 4, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 3, 1, 3, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 4, 1, 2, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 5, 0, 1, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].v, vecs[i].d, vecs[i].n);
      check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].en,
                vecs[i].ec, vecs[i].eo);
    end

    // Reset mid-stream with Count=3 and upstream still valid
    step(0, 1, 32'h11, 1);
    step(0, 1, 32'h22, 1);
    step(0, 1, 32'h33, 1);
    check_all("pre_rst", 1, 32'h11, 1, 3, 0);
    step(1, 1, 32'h44, 1);
    check_all("mid_rst1", 0, 0, 0, 0, 0);
    check("mid_rst1.data0", O_Data, 32'd0);
    step(1, 1, 32'h55, 0);
    check_all("mid_rst2", 0, 0, 0, 0, 0);
    // First token after reset is visible one edge later
    step(0, 1, 32'hA5, 1);
    check_all("post_rst", 1, 32'hA5, 0, 1, 0);
    step(0, 0, 0, 0);
    check_all("post_drain", 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
